// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 2:1 3-bit mux arbiter.
// Provides the data word type, select encodings and output-stage FSM states.
package mux_arb_pkg;

   typedef logic [2:0] word_t;

   localparam logic SEL_X = 1'b0;
   localparam logic SEL_Y = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/mux_2x1_3bit.sv
// 3-bit 2:1 mux datapath shared by the arbiter's two requesters.
// Ports: x/y data words in, sel (0 = x, 1 = y), m selected word out.
module mux_2x1_3bit
   import mux_arb_pkg::*;
(
   input  word_t x,
   input  word_t y,
   input  logic  sel,
   output word_t m
);

   assign m = (sel == SEL_Y) ? y : x;

endmodule

// File: rtl/mux_arb_2x1_3bit.sv
// Two-requester arbiter driving a shared 2:1 mux into a one-entry output stage.
// Ports: clk, rst_n (async low); X/X_valid/X_ready, Y/Y_valid/Y_ready requesters;
// M/M_valid/M_ready consumer; s registered select; busy activity flag.
// Build option: MUX_ARB_RR_EN selects round-robin, otherwise fixed priority.
module mux_arb_2x1_3bit
   import mux_arb_pkg::*;
#(
   parameter bit PRIO_INIT = 1'b0
)
(
   input  logic  clk,
   input  logic  rst_n,
   input  word_t X,
   input  logic  X_valid,
   output logic  X_ready,
   input  word_t Y,
   input  logic  Y_valid,
   output logic  Y_ready,
   output word_t M,
   output logic  M_valid,
   input  logic  M_ready,
   output logic  s,
   output logic  busy
);

   state_t state_q;
   state_t state_d;
   word_t  m_q;
   word_t  mux_out;
   logic   s_q;
   logic   sel_pri;
   logic   win_idx;
   logic   any_req;
   logic   space;
   logic   accept;

`ifdef MUX_ARB_RR_EN
   logic last;

   // Contention goes to whoever did not win the previous accept.
   assign sel_pri = ~last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= ~PRIO_INIT;
      end else if (accept) begin
         last <= win_idx;
      end
   end
`else
   assign sel_pri = PRIO_INIT;
`endif

   assign any_req = X_valid || Y_valid;

   always_comb begin
      win_idx = SEL_X;
      if (X_valid && Y_valid) begin
         win_idx = sel_pri;
      end else if (Y_valid) begin
         win_idx = SEL_Y;
      end
   end

   assign space = (state_q == EMPTY) || M_ready;

   // rst_n gates the readies so nothing is offered while reset is held.
   assign X_ready = rst_n && space && any_req && (win_idx == SEL_X);
   assign Y_ready = rst_n && space && any_req && (win_idx == SEL_Y);
   assign accept  = X_ready || Y_ready;

   mux_2x1_3bit u_mux (
      .x   (X),
      .y   (Y),
      .sel (win_idx),
      .m   (mux_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) state_d = FULL;
         end
         FULL: begin
            if (!accept && M_ready) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q <= '0;
         s_q <= SEL_X;
      end else if (accept) begin
         m_q <= mux_out;
         s_q <= win_idx;
      end
   end

   assign M       = m_q;
   assign s       = s_q;
   assign M_valid = (state_q == FULL);
   assign busy    = M_valid || X_valid || Y_valid;

endmodule

// File: doc/mux_arb_2x1_3bit.md
# mux_arb_2x1_3bit

Two-requester arbiter that shares one 3-bit 2:1 mux datapath between requester X and requester Y. It picks a winner each cycle, drives the mux select, and registers the selected word into a one-entry output stage with a valid/ready handshake. It sits between two 3-bit producers and a single 3-bit consumer, and is the only block that drives the mux select.

## Interface
Parameters:
- `PRIO_INIT`, default 0: requester favoured on first contention after reset (0 = X, 1 = Y).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `X` input 3: requester X data.
- `X_valid` input 1: X has a word.
- `X_ready` output 1: X word accepted this cycle when `X_valid` is also high.
- `Y` input 3: requester Y data.
- `Y_valid` input 1: Y has a word.
- `Y_ready` output 1: Y word accepted this cycle when `Y_valid` is also high.
- `M` output 3: registered output word.
- `M_valid` output 1: `M` holds a word.
- `M_ready` input 1: consumer takes `M` this cycle.
- `s` output 1: registered select that produced `M` (0 = X, 1 = Y).
- `busy` output 1: high when `M_valid` is high or either requester valid is high.

## Operation
- Output-stage FSM has two states, EMPTY and FULL; reset state is EMPTY.
- `space = !M_valid || M_ready`. This is the only condition that allows an accept.
- Winner is combinational from `X_valid`, `Y_valid` and the pointer `last`:
  - only one requester valid: that one wins;
  - both valid: the requester opposite to `last` wins;
  - neither valid: no winner.
- `X_ready = space && win_x` and `Y_ready = space && win_y`. At most one ready is high in any cycle.
- Accept (ready and valid both high):
  - `M` takes the muxed word;
  - `s` takes the winner index;
  - `M_valid` goes to 1;
  - `last` takes the winner index.
- Consumer takes the word (`M_valid && M_ready`) with no accept in the same cycle: `M_valid` goes to 0. `M` and `s` hold their values.
- Accept and drain in the same cycle: FULL stays FULL and the new word replaces the old one.
- Without an accept, `M` and `s` are stable while `M_valid` is high.
- Requesters hold data and valid until ready is seen. The block does not check this rule.
- Readies are never a function of the other requester's ready. No combinational loop through `M_ready` into a valid is allowed.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `M=3'b000`, `M_valid=0`, `s=0`;
  - `last = !PRIO_INIT`;
  - `X_ready`/`Y_ready` low while `rst_n` is low.
- Latency: a word accepted in cycle N appears on `M`/`M_valid` in cycle N+1.
- Throughput: one word per cycle while `M_ready` stays high.
- Fairness: under continuous contention, grants alternate X, Y, X, …, starting with `PRIO_INIT`.
- Back-pressure: with `M_ready` low and FULL, both readies are low and the pointer does not move.
- Reset mid-operation: the held word is dropped and `M_valid` falls immediately, asynchronously. An in-flight requester must re-present its word.

## Configuration
- `MUX_ARB_RR_EN` defined: round-robin arbitration as described above, with `last` updated on every accept.
- `MUX_ARB_RR_EN` undefined: fixed priority.
  - On contention, requester `PRIO_INIT` always wins.
  - `last` is not implemented.
  - All other behaviour is identical, including latency, handshake and reset values.

## Structure
- Shared package `mux_arb_pkg`:
  - `typedef logic [2:0] word_t`;
  - localparams `SEL_X=1'b0` and `SEL_Y=1'b1`;
  - FSM state enum `{EMPTY, FULL}`.
- One sub-module: the existing `mux_2x1_3bit` datapath, instantiated once.
  - Data inputs are X and Y.
  - Select input is the combinational winner index.
  - Its output feeds the `M` register.
- Arbitration logic, pointer and output stage stay in `mux_arb_2x1_3bit`.

## Test plan
- Reset release, idle inputs: `M=0`, `M_valid=0`, `s=0`, both readies 0 during reset. With `X_valid=1`, `X=3'b101`, `M_ready=1`: `X_ready=1`, and the next cycle gives `M=3'b101`, `s=0`.
- Continuous contention, `X=3'b001`, `Y=3'b110`, `M_ready=1`, `PRIO_INIT=0`, RR enabled: `M` sequence is 001, 110, 001, 110 with `s` toggling 0, 1, 0, 1.
- Same stimulus with `MUX_ARB_RR_EN` undefined: `M` stays 001 and `s` stays 0 every cycle, and `Y_ready` never rises.
- Back-pressure: fill with `Y=3'b011`, hold `M_ready=0` for 4 cycles while X is valid. `M` stays 011, `M_valid` stays 1 and both readies stay 0. On `M_ready=1`, X is accepted and `M=X` the next cycle.
- Simultaneous drain and accept: FULL with `M=3'b010` and `M_ready=1`, `Y_valid=1`, `Y=3'b111`. Next cycle `M=3'b111`, `M_valid=1`, with no bubble cycle.
- Reset mid-operation: assert `rst_n=0` while FULL. `M_valid` drops to 0 without waiting for a clock edge, and after release the pointer favours `PRIO_INIT`.
